choice_menu_ctrl: RTL and testbench

- Sequences the 72x40 "choice" cursor sprite on the title/menu screen.
- Turns keyboard key levels into a cursor index over NUM_OPT vertically stacked options.
- Drives the sprite renderer's posx/posy/isplay inputs. Cursor moves are applied only at frame start, so the cursor never tears mid-frame.
- Reports the confirmed option to the game FSM through a valid/ack handshake.

---
 rtl/choice_menu_ctrl.sv | 156 +++++++++++++++
 tb/tb_choice_menu_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/choice_menu_ctrl.sv
// Menu cursor controller: turns key levels into a cursor index, positions the "choice"
// sprite at frame boundaries, blinks it while browsing, and hands the confirmed option over.
module choice_menu_ctrl #(
  parameter int NUM_OPT   = 3,
  parameter int BASE_X    = 284,
  parameter int BASE_Y    = 200,
  parameter int STEP_Y    = 48,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       menu_en,
  input  logic       frame_start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_ok,
  input  logic       sel_ack,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       isplay,
  output logic [1:0] sel_idx,
  output logic       sel_valid,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_cur_pend,
  output logic [1:0] dbg_cur_disp
);

  // Handshake: sel_valid rises with sel_idx loaded and both stay stable until sel_ack
  // is sampled high on a clk edge; sel_valid then drops on that same edge.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BROWSE  = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  localparam int         CNT_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [1:0] LP_LAST     = 2'(NUM_OPT - 1);
  localparam logic [9:0] LP_BASE_X   = 10'(BASE_X);
  localparam logic [8:0] LP_BASE_Y   = 9'(BASE_Y);
  localparam logic [8:0] LP_STEP_Y   = 9'(STEP_Y);

  state_t           r_state;
  logic [1:0]       r_cur_pend;
  logic [1:0]       r_cur_disp;
  logic [8:0]       r_posy;
  logic             r_isplay;
  logic [1:0]       r_sel_idx;
  logic             r_sel_valid;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_ph;
  logic             r_up_q;
  logic             r_down_q;
  logic             r_ok_q;

  logic             w_press_up;
  logic             w_press_down;
  logic             w_press_ok;
  logic             w_move;
  logic [1:0]       w_cur_next;
  logic [8:0]       w_posy_next;

  assign w_press_up   = key_up & ~r_up_q;
  assign w_press_down = key_down & ~r_down_q;
  assign w_press_ok   = key_ok & ~r_ok_q;

  // Simultaneous up+down cancels; confirm outranks any move.
  assign w_move = (r_state == ST_BROWSE) & menu_en & ~w_press_ok & (w_press_up ^ w_press_down);

  always_comb begin
    w_cur_next = r_cur_pend;
    if (w_move) begin
      if (w_press_up) w_cur_next = (r_cur_pend == 2'd0) ? LP_LAST : r_cur_pend - 2'd1;
      else            w_cur_next = (r_cur_pend == LP_LAST) ? 2'd0 : r_cur_pend + 2'd1;
    end
  end

  assign w_posy_next = LP_BASE_Y + 9'(w_cur_next) * LP_STEP_Y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_pend  <= 2'd0;
      r_cur_disp  <= 2'd0;
      r_posy      <= LP_BASE_Y;
      r_isplay    <= 1'b0;
      r_sel_idx   <= 2'd0;
      r_sel_valid <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b1;
      r_up_q      <= 1'b0;
      r_down_q    <= 1'b0;
      r_ok_q      <= 1'b0;
    end else begin
      r_up_q     <= key_up;
      r_down_q   <= key_down;
      r_ok_q     <= key_ok;
      r_cur_pend <= w_cur_next;
      if (frame_start) begin
        r_cur_disp <= w_cur_next;
        r_posy     <= w_posy_next;
      end
      case (r_state)
        ST_IDLE: begin
          r_isplay    <= 1'b0;
          r_blink_cnt <= '0;
          r_blink_ph  <= 1'b1;
          if (menu_en) r_state <= ST_BROWSE;
        end
        ST_BROWSE: begin
          r_isplay <= r_blink_ph;
          if (!menu_en) begin
            r_state     <= ST_IDLE;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
          end else if (w_press_ok) begin
            r_state     <= ST_CONFIRM;
            r_sel_idx   <= r_cur_pend;
            r_sel_valid <= 1'b1;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
          end else if (w_move) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
          end else if (r_blink_cnt == LP_CNT_LAST) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
          end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
          end
        end
        ST_CONFIRM: begin
          r_isplay    <= 1'b1;
          r_blink_cnt <= '0;
          r_blink_ph  <= 1'b1;
          if (!menu_en || sel_ack) begin
            r_sel_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign posx         = LP_BASE_X;
  assign posy         = r_posy;
  assign isplay       = r_isplay;
  assign sel_idx      = r_sel_idx;
  assign sel_valid    = r_sel_valid;
  assign dbg_state    = r_state;
  assign dbg_cur_pend = r_cur_pend;
  assign dbg_cur_disp = r_cur_disp;

endmodule

// File: tb/tb_choice_menu_ctrl.sv
// Directed bench for choice_menu_ctrl with a short blink period (BLINK_DIV=4).
module tb_choice_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       menu_en, frame_start, key_up, key_down, key_ok, sel_ack;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       isplay;
  logic [1:0] sel_idx;
  logic       sel_valid;
  logic [1:0] dbg_state, dbg_cur_pend, dbg_cur_disp;

  int n_checks = 0;
  int n_pass   = 0;

  choice_menu_ctrl #(
    .NUM_OPT(3), .BASE_X(284), .BASE_Y(200), .STEP_Y(48), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .menu_en(menu_en), .frame_start(frame_start),
    .key_up(key_up), .key_down(key_down), .key_ok(key_ok), .sel_ack(sel_ack),
    .posx(posx), .posy(posy), .isplay(isplay), .sel_idx(sel_idx),
    .sel_valid(sel_valid), .dbg_state(dbg_state),
    .dbg_cur_pend(dbg_cur_pend), .dbg_cur_disp(dbg_cur_disp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; menu_en = 1'b0; frame_start = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_ok = 1'b0; sel_ack = 1'b0;
    step(2);
    check("rst_posx", posx, 284);
    check("rst_posy", posy, 200);
    check("rst_isplay", isplay, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_sel_idx", sel_idx, 0);
    check("rst_state", dbg_state, 0);

    // Enter BROWSE; isplay lags one clk, then 4 high / 4 low
    rst = 1'b0; menu_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check($sformatf("blink_%0d", i), isplay, ((i >= 2 && i <= 5) || i == 10) ? 1 : 0);
    end
    check("browse_state", dbg_state, 1);
    check("browse_posx", posx, 284);
    check("browse_posy", posy, 200);
    check("browse_sel_valid", sel_valid, 0);

    // Up from 0 wraps to 2, held key gives one press; posy waits for frame
    key_up = 1'b1;
    step(10);
    check("up_wrap_idx", dbg_cur_pend, 2);
    check("up_posy_hold", posy, 200);
    key_up = 1'b0;
    step(1);
    frame_pulse();
    check("up_posy_frame", posy, 296);
    check("up_cur_disp", dbg_cur_disp, 2);

    // Down wraps 2 -> 0, then down coinciding with frame uses new index
    key_down = 1'b1;
    step(1);
    key_down = 1'b0;
    check("down_wrap_idx", dbg_cur_pend, 0);
    step(1);
    frame_pulse();
    check("down_posy0", posy, 200);
    key_down = 1'b1; frame_start = 1'b1;
    step(1);
    key_down = 1'b0; frame_start = 1'b0;
    check("down_idx1", dbg_cur_pend, 1);
    check("down_same_frame_posy", posy, 248);
    step(1);
    key_up = 1'b1; key_down = 1'b1;
    step(1);
    key_up = 1'b0; key_down = 1'b0;
    check("updown_cancel", dbg_cur_pend, 1);

    // Confirm index 1, hold without ack, keys ignored
    step(1);
    key_ok = 1'b1;
    step(1);
    key_ok = 1'b0;
    check("ok_state", dbg_state, 2);
    check("ok_sel_valid", sel_valid, 1);
    check("ok_sel_idx", sel_idx, 1);
    key_up = 1'b1;
    step(1);
    key_up = 1'b0;
    frame_pulse();
    step(18);
    check("hold_sel_valid", sel_valid, 1);
    check("hold_sel_idx", sel_idx, 1);
    check("hold_isplay", isplay, 1);
    check("confirm_keys_ignored", dbg_cur_pend, 1);
    check("confirm_posy", posy, 248);
    sel_ack = 1'b1;
    step(1);
    sel_ack = 1'b0;
    check("ack_sel_valid", sel_valid, 0);
    check("ack_state", dbg_state, 0);
    step(1);
    check("ack_isplay_off", isplay, 0);
    check("ack_rebrowse", dbg_state, 1);

    // menu_en drop in CONFIRM aborts the selection
    key_ok = 1'b1;
    step(1);
    key_ok = 1'b0;
    check("ok2_sel_valid", sel_valid, 1);
    check("ok2_sel_idx", sel_idx, 1);
    menu_en = 1'b0;
    step(1);
    check("abort_sel_valid", sel_valid, 0);
    check("abort_state", dbg_state, 0);

    // Index persists; move to 2, then async reset mid-BROWSE
    menu_en = 1'b1;
    step(1);
    check("persist_idx", dbg_cur_pend, 1);
    key_down = 1'b1;
    step(1);
    key_down = 1'b0;
    frame_pulse();
    check("pre_rst_posy", posy, 296);
    check("pre_rst_isplay", isplay, 1);
    rst = 1'b1;
    #1;
    check("async_rst_posy", posy, 200);
    check("async_rst_isplay", isplay, 0);
    check("async_rst_state", dbg_state, 0);
    check("async_rst_idx", dbg_cur_pend, 0);
    check("async_rst_sel_valid", sel_valid, 0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
